score_uart_tx: RTL and testbench
================================

SCORE_UART_TX -- requirements
Module: score_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; bit period DIV = CLK_HZ/BAUD clock cycles (integer division, 104 at defaults).
REQ-003 SHALL have port clk  input  1  system clock; all state is updated on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to transmit the current score.
REQ-006 SHALL have port score  input  20  unsigned binary score from the game FSM; sampled on an accepted start.
REQ-007 SHALL have port tx  output  1  UART line, 8N1, idle high.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last stop bit of a message.

Function
REQ-010 SHALL accept start only in IDLE; start while busy SHALL be ignored, with no queuing and no effect on the message in flight.
REQ-011 SHALL latch score on the accepted-start edge; later changes on score SHALL NOT affect the message.
REQ-012 SHALL saturate latched values above 999999 to 999999.
REQ-013 SHALL convert the latched value to 6 BCD digits by sequential double-dabble in exactly 20 cycles (state CONVERT).
REQ-014 SHALL transmit 8 bytes in this order: 6 ASCII digits, most significant first, with leading zeros kept (0x30+digit); then 0x0D; then 0x0A.
REQ-015 SHALL frame each byte as 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1); each bit SHALL be held exactly DIV cycles.
REQ-016 SHALL send bytes back to back: the next start bit begins the cycle after the previous stop bit ends.
REQ-017 SHALL follow the state sequence IDLE -> CONVERT -> SEND (byte index 0..7, bit index 0..9) -> IDLE.
- done pulses on the SEND->IDLE transition.
- busy falls on that same edge.
REQ-018 SHALL drive the start bit of byte 0 low on the cycle after CONVERT completes.
REQ-019 SHALL allow a start that coincides with the done pulse to be ignored; a start is accepted from the next cycle.
REQ-020 SHALL give a total message duration of 20 + 80*DIV cycles (+1 for the start-accept cycle), plus or minus 1 for pipelining; this figure SHALL be fixed and documented in the RTL header.

Reset
REQ-021 SHALL, while rst is high, hold tx=1, busy=0, done=0, state IDLE, and all counters at 0.
REQ-022 SHALL, when rst is asserted mid-message, abort the message immediately (asynchronously).
- tx returns high with no glitch low.
- No done pulse is produced.
REQ-023 SHALL, after rst deasserts, accept start on the first clk edge.

Structure
REQ-024 SHALL place the following in shared package score_uart_pkg:
- state enum (IDLE, CONVERT, SEND);
- ASCII constants ZERO=0x30, CR=0x0D, LF=0x0A;
- MAX_SCORE=999999;
- MSG_LEN=8.
REQ-025 SHALL implement the double-dabble converter as sub-module bin2bcd6.
- Ports: clk, rst, go, bin[19:0], bcd[23:0], ready.
- 20-cycle latency.
REQ-026 SHALL use one baud counter of width ceil(log2(DIV)) that reloads at each bit boundary; no fractional baud.
REQ-027 SHALL register tx from a flop, never driving it combinationally.

Verification
REQ-028 SHALL verify decoding: start with score=123456 -> tx decodes 0x31 0x32 0x33 0x34 0x35 0x36 0x0D 0x0A, then one done pulse.
REQ-029 SHALL verify saturation and zero-fill:
- score=0 -> six 0x30 then 0x0D 0x0A;
- score=1048575 -> six 0x39 then 0x0D 0x0A.
REQ-030 SHALL verify bit timing at DIV=104:
- start bit low exactly 104 cycles;
- frame 1040 cycles;
- done within 20+8320+/-2 cycles of start.
REQ-031 SHALL verify busy handling: start pulsed during byte 3 with score changed to 42 -> ignored; original 8 bytes sent unaltered; busy stays high.
REQ-032 SHALL verify reset mid-message: rst asserted during byte 2 data bits -> tx=1 and busy=0 at once, no done; a fresh start after release sends a full message.
REQ-033 SHALL verify start/done overlap: start asserted on the done cycle -> no new message; start one cycle later -> new message accepted.

Source files
------------

// File: rtl/score_uart_pkg.sv
// Shared types and constants for the score UART transmitter: FSM states,
// ASCII framing bytes, score limit and message byte selection.
package score_uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SEND    = 2'd2
    } state_e;

    localparam logic [7:0]  ZERO      = 8'h30;
    localparam logic [7:0]  CR        = 8'h0D;
    localparam logic [7:0]  LF        = 8'h0A;
    localparam logic [19:0] MAX_SCORE = 20'd999999;
    localparam int unsigned MSG_LEN   = 8;
    localparam int unsigned BIN_W     = 20;

    // Double-dabble correction: a digit of 5 or more must absorb +3 before the shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [7:0] msg_byte(input logic [23:0] bcd, input logic [2:0] idx);
        case (idx)
            3'd0:    return ZERO | {4'h0, bcd[23:20]};
            3'd1:    return ZERO | {4'h0, bcd[19:16]};
            3'd2:    return ZERO | {4'h0, bcd[15:12]};
            3'd3:    return ZERO | {4'h0, bcd[11:8]};
            3'd4:    return ZERO | {4'h0, bcd[7:4]};
            3'd5:    return ZERO | {4'h0, bcd[3:0]};
            3'd6:    return CR;
            default: return LF;
        endcase
    endfunction

endpackage

// File: rtl/score_uart_tx_bin2bcd6.sv
// Sequential double-dabble: 20-bit binary to 6 BCD digits. The value is captured
// on go, ready pulses once the 20th shift has completed and bcd then holds steady.
module bin2bcd6
    import score_uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [19:0] bin,
    output logic [23:0] bcd,
    output logic        ready
);

    logic [4:0]  cnt_q,   cnt_d;
    logic [19:0] shift_q, shift_d;
    logic [23:0] bcd_q,   bcd_d;
    logic        ready_q, ready_d;
    logic [23:0] adj;

    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            adj[i*4 +: 4] = dd_adjust(bcd_q[i*4 +: 4]);
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        ready_d = 1'b0;
        if (go) begin
            // First iteration folded into the load: adjusting an all-zero BCD is a no-op.
            bcd_d   = {23'd0, bin[19]};
            shift_d = {bin[18:0], 1'b0};
            cnt_d   = 5'(BIN_W - 1);
        end else if (cnt_q != '0) begin
            bcd_d   = {adj[22:0], shift_q[19]};
            shift_d = {shift_q[18:0], 1'b0};
            cnt_d   = cnt_q - 5'd1;
            ready_d = (cnt_q == 5'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            ready_q <= ready_d;
        end
    end

    assign bcd   = bcd_q;
    assign ready = ready_q;

endmodule

// File: rtl/score_uart_tx.sv
// Sends a saturated 6-digit decimal score plus CR LF over 8N1 UART. From the start
// accept edge to the done edge takes exactly 20 + 80*DIV cycles (8340 at defaults).
module score_uart_tx
    import score_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] score,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DIV    = CLK_HZ / BAUD;
    localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);

    state_e            state_q, state_d;
    logic [2:0]        byte_q,  byte_d;
    logic [3:0]        bit_q,   bit_d;
    logic [BAUD_W-1:0] baud_q,  baud_d;
    logic              tx_q,    tx_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic        accept;
    logic [19:0] sat_score;
    logic [23:0] bcd;
    logic        conv_ready;
    logic [7:0]  cur_byte;

    // A start landing on the done cycle is dropped so back-to-back requests need a gap.
    assign accept    = start && (state_q == IDLE) && !done_q;
    assign sat_score = (score > MAX_SCORE) ? MAX_SCORE : score;
    assign cur_byte  = msg_byte(bcd, byte_q);

    bin2bcd6 u_conv (
        .clk   (clk),
        .rst   (rst),
        .go    (accept),
        .bin   (sat_score),
        .bcd   (bcd),
        .ready (conv_ready)
    );

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CONVERT;
                    busy_d  = 1'b1;
                end
            end
            CONVERT: begin
                if (conv_ready) begin
                    state_d = SEND;
                    tx_d    = 1'b0;
                    byte_d  = '0;
                    bit_d   = '0;
                    baud_d  = '0;
                end
            end
            SEND: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d = '0;
                        if (byte_q == 3'(MSG_LEN - 1)) begin
                            state_d = IDLE;
                            byte_d  = '0;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            byte_d = byte_q + 3'd1;
                            tx_d   = 1'b0;
                        end
                    end else begin
                        // Next bit is bit_q+1: data bit bit_q for 0..7, stop bit after that.
                        bit_d = bit_q + 4'd1;
                        tx_d  = (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            byte_q  <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_score_uart_tx.sv
// Scoreboard bench for score_uart_tx: expected bytes are queued at each accepted
// start and compared against bytes recovered from the tx line.
module tb_score_uart_tx;

    localparam int unsigned CLK_HZ = 12000000;
    localparam int unsigned BAUD   = 115200;
    localparam int unsigned DIV    = CLK_HZ / BAUD;
    localparam int unsigned FRAME  = 10 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] score;
    logic        tx;
    logic        busy;
    logic        done;

    score_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .score (score),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    time done_t   = 0;
    time t_acc    = 0;

    logic [7:0] exp_q[$];

    logic [7:0] rx_b[8];
    int         rx_gap[8];
    bit         rx_flat[8];
    bit         rx_stop[8];
    bit         rx_to;
    time        rx_first_t;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_t = $time - 5;
        end
    end

    initial begin
        #(1_200_000 * 1ns);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_expected(input logic [19:0] s);
        int v;
        logic [7:0] m[6];
        v = (s > 20'd999999) ? 999999 : int'(s);
        for (int i = 5; i >= 0; i--) begin
            m[i] = 8'(48 + (v % 10));
            v = v / 10;
        end
        for (int i = 0; i < 6; i++) exp_q.push_back(m[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic do_start(input logic [19:0] s);
        @(posedge clk);
        #1 start = 1'b1;
        score = s;
        push_expected(s);
        @(posedge clk);
        t_acc = $time;
        #1 start = 1'b0;
        score = 20'($urandom);
    endtask

    // Recovers 8 frames from tx, sampling once per cycle on the falling edge.
    task automatic collect_msg(input int first_budget);
        rx_to = 1'b0;
        for (int b = 0; b < 8; b++) begin
            logic s[FRAME];
            int   gap;
            int   budget;
            bit   found;
            gap    = 0;
            found  = 1'b0;
            budget = (b == 0) ? first_budget : 2 * int'(DIV);
            while (!found) begin
                @(negedge clk);
                if (tx === 1'b0) found = 1'b1;
                else begin
                    gap++;
                    if (gap > budget) begin
                        rx_to = 1'b1;
                        return;
                    end
                end
            end
            if (b == 0) rx_first_t = $time - 5;
            s[0] = tx;
            for (int k = 1; k < int'(FRAME); k++) begin
                @(negedge clk);
                s[k] = tx;
            end
            rx_gap[b]  = gap;
            rx_flat[b] = 1'b1;
            for (int j = 0; j < 10; j++)
                for (int k = j * int'(DIV); k < (j + 1) * int'(DIV); k++)
                    if (s[k] !== s[j * int'(DIV)]) rx_flat[b] = 1'b0;
            rx_stop[b] = (s[9 * DIV] === 1'b1);
            for (int i = 0; i < 8; i++) rx_b[b][i] = s[(i + 1) * DIV + DIV / 2];
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        score = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (tx !== 1'b1)   $display("FAIL reset_tx got %b want 1", tx);     else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_decode;
        int d0;
        int lat;
        d0 = done_cnt;
        do_start(20'd123456);
        total_cnt++; if (busy !== 1'b1) $display("FAIL decode_busy_rise got %b want 1", busy); else pass_cnt++;
        collect_msg(60);
        total_cnt++; if (rx_to) $display("FAIL decode_timeout got timeout want 8 frames"); else pass_cnt++;
        for (int b = 0; b < 8 && !rx_to; b++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            total_cnt++; if (rx_b[b] !== e) $display("FAIL decode_byte%0d got %h want %h", b, rx_b[b], e); else pass_cnt++;
            total_cnt++;
            if (!(rx_flat[b] && rx_stop[b] && (b == 0 || rx_gap[b] == 0)))
                $display("FAIL decode_frame%0d got flat=%0b stop=%0b gap=%0d want 1 1 0", b, rx_flat[b], rx_stop[b], rx_gap[b]);
            else pass_cnt++;
        end
        exp_q.delete();
        @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL decode_done got %b want 1", done); else pass_cnt++;
        #1;
        lat = int'((rx_first_t - t_acc) / 10);
        total_cnt++; if (lat !== 20) $display("FAIL first_start_latency got %0d want 20", lat); else pass_cnt++;
        lat = int'((done_t - t_acc) / 10);
        total_cnt++;
        if (lat < 20 + 80 * int'(DIV) - 2 || lat > 20 + 80 * int'(DIV) + 2)
            $display("FAIL done_latency got %0d want %0d+/-2", lat, 20 + 80 * DIV);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL done_single got %b want 0", done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL decode_busy_fall got %b want 0", busy); else pass_cnt++;
        repeat (20) @(posedge clk);
        #1;
        total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL decode_done_count got %0d want 1", done_cnt - d0); else pass_cnt++;
    endtask

    task automatic test_saturation;
        logic [19:0] pats[2];
        pats[0] = 20'd0;
        pats[1] = 20'd1048575;
        for (int p = 0; p < 2; p++) begin
            do_start(pats[p]);
            collect_msg(60);
            total_cnt++; if (rx_to) $display("FAIL sat%0d_timeout got timeout want 8 frames", p); else pass_cnt++;
            for (int b = 0; b < 8 && !rx_to; b++) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                total_cnt++; if (rx_b[b] !== e) $display("FAIL sat%0d_byte%0d got %h want %h", p, b, rx_b[b], e); else pass_cnt++;
            end
            exp_q.delete();
            @(negedge clk);
            total_cnt++; if (done !== 1'b1) $display("FAIL sat%0d_done got %b want 1", p, done); else pass_cnt++;
            repeat (3) @(posedge clk);
        end
    endtask

    task automatic test_busy;
        int d0;
        d0 = done_cnt;
        do_start(20'd654321);
        fork
            collect_msg(60);
            begin
                repeat (20 + 3 * FRAME + 4 * DIV) @(negedge clk);
                @(posedge clk);
                #1 start = 1'b1;
                score = 20'd42;
                @(posedge clk);
                #1 start = 1'b0;
                total_cnt++; if (busy !== 1'b1) $display("FAIL busy_hold got %b want 1", busy); else pass_cnt++;
                repeat (DIV) @(negedge clk);
                total_cnt++; if (busy !== 1'b1) $display("FAIL busy_hold_late got %b want 1", busy); else pass_cnt++;
            end
        join
        total_cnt++; if (rx_to) $display("FAIL busy_timeout got timeout want 8 frames"); else pass_cnt++;
        for (int b = 0; b < 8 && !rx_to; b++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            total_cnt++; if (rx_b[b] !== e) $display("FAIL busy_byte%0d got %h want %h", b, rx_b[b], e); else pass_cnt++;
        end
        exp_q.delete();
        @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL busy_done got %b want 1", done); else pass_cnt++;
        repeat (200) @(posedge clk);
        #1;
        total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL busy_no_requeue got %0d dones want 1", done_cnt - d0); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL busy_idle_after got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (tx !== 1'b1) $display("FAIL busy_tx_idle got %b want 1", tx); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int d0;
        d0 = done_cnt;
        do_start(20'd777777);
        repeat (20 + 2 * FRAME + 3 * DIV) @(negedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        total_cnt++; if (tx !== 1'b1)   $display("FAIL rstmid_tx got %b want 1", tx);     else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_cnt++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (tx !== 1'b1) $display("FAIL rstmid_tx_hold got %b want 1", tx); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 !== 0) $display("FAIL rstmid_no_done got %0d want 0", done_cnt - d0); else pass_cnt++;
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b1;
        score = 20'd246813;
        push_expected(20'd246813);
        @(posedge clk);
        t_acc = $time;
        #1 start = 1'b0;
        score = 20'd5;
        total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_first_edge_accept got %b want 1", busy); else pass_cnt++;
        collect_msg(60);
        total_cnt++; if (rx_to) $display("FAIL rstmid_timeout got timeout want 8 frames"); else pass_cnt++;
        for (int b = 0; b < 8 && !rx_to; b++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            total_cnt++; if (rx_b[b] !== e) $display("FAIL rstmid_byte%0d got %h want %h", b, rx_b[b], e); else pass_cnt++;
        end
        exp_q.delete();
        @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL rstmid_done got %b want 1", done); else pass_cnt++;
        #1;
        total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL rstmid_done_count got %0d want 1", done_cnt - d0); else pass_cnt++;
    endtask

    task automatic test_overlap;
        do_start(20'd314159);
        collect_msg(60);
        total_cnt++; if (rx_to) $display("FAIL ovl_first_timeout got timeout want 8 frames"); else pass_cnt++;
        for (int b = 0; b < 8 && !rx_to; b++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            total_cnt++; if (rx_b[b] !== e) $display("FAIL ovl_first_byte%0d got %h want %h", b, rx_b[b], e); else pass_cnt++;
        end
        exp_q.delete();
        @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL ovl_done got %b want 1", done); else pass_cnt++;
        start = 1'b1;
        score = 20'd111111;
        @(posedge clk);
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL ovl_start_on_done got busy=%b want 0", busy); else pass_cnt++;
        push_expected(20'd111111);
        @(posedge clk);
        t_acc = $time;
        #1 start = 1'b0;
        score = 20'd999;
        total_cnt++; if (busy !== 1'b1) $display("FAIL ovl_next_cycle_accept got busy=%b want 1", busy); else pass_cnt++;
        collect_msg(60);
        total_cnt++; if (rx_to) $display("FAIL ovl_second_timeout got timeout want 8 frames"); else pass_cnt++;
        for (int b = 0; b < 8 && !rx_to; b++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            total_cnt++; if (rx_b[b] !== e) $display("FAIL ovl_second_byte%0d got %h want %h", b, rx_b[b], e); else pass_cnt++;
        end
        exp_q.delete();
        @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL ovl_second_done got %b want 1", done); else pass_cnt++;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        score = '0;
        test_reset;
        test_decode;
        test_saturation;
        test_busy;
        test_reset_mid;
        test_overlap;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
